// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// Module : cdb_pkg
// Desc   : Shared sizing helpers and delay-line element type for
//          credit_delay_buffer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cdb_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } dl_elem_t;

endpackage

`default_nettype wire

// File: rtl/valid_delay_line.sv
// ---------------------------------------------------------------------------
// Module : valid_delay_line
// Desc   : STAGES-deep valid-tagged shift register; only valid bits reset.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module valid_delay_line #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_pipe
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             v_prev;
        logic [WIDTH-1:0] d_prev;
        logic             v_q;
        logic [WIDTH-1:0] d_q;

        if (i == 0) begin : g_first
          assign v_prev = in_valid;
          assign d_prev = in_data;
        end else begin : g_next
          assign v_prev = g_stage[i-1].v_q;
          assign d_prev = g_stage[i-1].d_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) v_q <= 1'b0;
          else          v_q <= v_prev;
        end

        // Data only moves with a valid word so idle stages never toggle.
        always_ff @(posedge clk) begin
          if (v_prev) d_q <= d_prev;
        end
      end

      assign out_valid = g_stage[STAGES-1].v_q;
      assign out_data  = g_stage[STAGES-1].d_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/credit_delay_buffer.sv
// ---------------------------------------------------------------------------
// Module : credit_delay_buffer
// Desc   : Credit-bounded elastic wrapper: delay line feeding an output FIFO.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module credit_delay_buffer
  import cdb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [credit_width(DEPTH)-1:0] credits
);

  localparam int CW    = credit_width(DEPTH);
  localparam int PW    = ptr_width(DEPTH);
  localparam int SLOTS = 1 << PW;

  logic             accept;
  logic             pop;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_wdata;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] storage [SLOTS];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (credits != '0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = storage[rd_ptr];

  valid_delay_line #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_delay (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (accept),
    .in_data   (in_data),
    .out_valid (fifo_wr),
    .out_data  (fifo_wdata)
  );

  // Credits cover words in flight plus words stored, so a write never finds the FIFO full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CW'(DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !accept) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SLOTS; i++) storage[i] <= '0;
    end else begin
      if (fifo_wr) begin
        storage[wr_ptr] <= fifo_wdata;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_wr && count == CW'(DEPTH)))
    else $error("credit_delay_buffer: FIFO write while full");

endmodule

`default_nettype wire
